control_unit: RTL
=================

Name: control_unit

Overview:
Multi-cycle main control FSM for the RV32I core. It sits directly upstream of the ALU and drives the ALU's 4-bit OP code, the datapath mux selects and the write strobes. It consumes the opcode/funct fields of the registered instruction and the ALU's ZERO flag. It executes one instruction every 3–5 cycles.

Parameters:
none (RV32I fixed; all encodings are constants in the shared header)

Ports:
CLK  in  1  system clock, rising edge
RSTN  in  1  asynchronous active-low reset
OPCODE  in  7  instr[6:0] from instruction register
FUNCT3  in  3  instr[14:12]
FUNCT7_5  in  1  instr[30]
ZERO  in  1  ALU ZERO flag (RESULT == 0)
ALU_OP  out  4  ALU OP: [3:2] 00 arith, 01 logic, 10 shift; [1:0] arith ADD=00 SUB=01 SLT=10 SLTU=11, logic AND=00 OR=01 XOR=10, shift SLL=00 SRL=01 SRA=10
ALU_SRC_A  out  2  00 PC, 01 OLD_PC, 10 RD1, 11 zero
ALU_SRC_B  out  2  00 RD2, 01 IMM, 10 const 4
RESULT_SRC  out  2  00 ALU_OUT reg, 01 DATA reg, 10 ALU RESULT direct
ADR_SRC  out  1  memory address: 0 PC, 1 RESULT bus
IMM_SRC  out  3  000 I, 001 S, 010 B, 011 J, 100 U
IR_WRITE  out  1  load instruction register (and OLD_PC)
PC_WRITE  out  1  load PC from RESULT bus
REG_WRITE  out  1  register file write enable
MEM_WRITE  out  1  data memory write enable
ILLEGAL  out  1  sticky: unsupported instruction seen

Behaviour:
- Reset (RSTN low, async): state <= FETCH, ILLEGAL <= 0; all strobes (IR_WRITE, PC_WRITE, REG_WRITE, MEM_WRITE) forced 0 while RSTN is low. First FETCH happens in the first cycle after release. Reset mid-instruction abandons it; no partial writes follow.
- Moore outputs decode state only. Exceptions: ALU_OP in EXECUTE_R/EXECUTE_I/BRANCH (also decodes funct fields); PC_WRITE in BRANCH (also uses ZERO). IMM_SRC decodes OPCODE combinationally in every state.
- Unlisted outputs are 0. Default ALU_OP is ADD.
- State actions and transitions:
  - FETCH: ADR_SRC=0, IR_WRITE, A=PC, B=4, ADD, RESULT_SRC=10, PC_WRITE -> DECODE.
  - DECODE: A=OLD_PC, B=IMM, ADD (branch/JAL/AUIPC target into ALU_OUT). Next state by opcode:
    - 0000011/0100011 -> MEM_ADR
    - 0110011 -> EXECUTE_R
    - 0010011 -> EXECUTE_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 0110111 -> LUI
    - 0010111 -> ALU_WB
    - other -> HALT
  - MEM_ADR: A=RD1, B=IMM, ADD -> MEM_READ (load) or MEM_WRITE_S (store).
  - MEM_READ: RESULT_SRC=00, ADR_SRC=1 -> MEM_WB.
  - MEM_WB: RESULT_SRC=01, REG_WRITE -> FETCH.
  - MEM_WRITE_S: RESULT_SRC=00, ADR_SRC=1, MEM_WRITE -> FETCH.
  - EXECUTE_R: A=RD1, B=RD2, decoded op -> ALU_WB.
  - EXECUTE_I: A=RD1, B=IMM, decoded op -> ALU_WB.
  - ALU_WB: RESULT_SRC=00, REG_WRITE -> FETCH.
  - LUI: A=zero, B=IMM, ADD -> ALU_WB.
  - JALR_ADR: A=RD1, B=IMM, ADD -> JAL. Bit-0 clearing of the target is done in the datapath.
  - JAL: A=OLD_PC, B=4, ADD, RESULT_SRC=00, PC_WRITE -> ALU_WB.
  - BRANCH: A=RD1, B=RD2, RESULT_SRC=00 -> FETCH. funct3 selects:
    - 000 BEQ: SUB, take=ZERO
    - 001 BNE: SUB, take=~ZERO
    - 100/110 BLT/BLTU: SLT/SLTU, take=~ZERO
    - 101/111 BGE/BGEU: SLT/SLTU, take=ZERO
    - PC_WRITE=take
    - funct3 010/011: -> HALT, no PC_WRITE
  - HALT: all strobes 0, ILLEGAL=1, remains until RSTN.
- Operation decode (R and I): funct3 000 ADD, except R-type with FUNCT7_5=1 -> SUB; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if FUNCT7_5=1; 110 OR; 111 AND.
- Latency in cycles incl. FETCH: AUIPC/BRANCH 3; R/I/LUI/store/JAL 4; load/JALR 5.
- At most one of REG_WRITE/MEM_WRITE/IR_WRITE is high in any cycle.

Decomposition:
- Shared header riscv_defs.vh holds:
  - opcode constants
  - ALU_OP encodings (ALU_ADD…ALU_SRA)
  - mux-select codes (SRC_A_*, SRC_B_*, RES_*, IMM_*)
  - state encodings
- Sub-module alu_decoder: combinational; inputs mode (R/I/branch), FUNCT3, FUNCT7_5; output ALU_OP. The FSM instantiates it.

Test Plan:
- Hold RSTN=0 for 3 cycles, release -> strobes 0 during reset; cycle 1 after release: IR_WRITE=1, PC_WRITE=1, ALU_OP=0000, ALU_SRC_B=10.
- R-type SUB (OPCODE=0110011, FUNCT3=000, FUNCT7_5=1) -> EXECUTE_R cycle ALU_OP=0001, A=10, B=00; ALU_WB has REG_WRITE=1; next FETCH at cycle 5.
- SRAI (0010011, 101, FUNCT7_5=1) -> ALU_OP=1010, B=01; SLTU R-type -> 0011; XOR -> 0110.
- Branches, 3-cycle sequence each:
  - BEQ ZERO=1 -> PC_WRITE=1 in cycle 3.
  - BEQ ZERO=0 -> PC_WRITE=0.
  - BGE (101) ZERO=1 -> ALU_OP=0010, PC_WRITE=1.
- Load -> states FETCH, DECODE, MEM_ADR, MEM_READ (ADR_SRC=1), MEM_WB (RESULT_SRC=01, REG_WRITE); store -> MEM_WRITE=1 in cycle 4 only.
- Opcode 1111111 -> HALT after DECODE, ILLEGAL=1 and no strobes for 10 cycles. Then RSTN pulse while in HALT and mid-load (MEM_READ) -> ILLEGAL=0, FETCH after release, no MEM_WB write.

Source files
------------

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - RV32I encodings, datapath select codes and FSM states
package control_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [1:0] {
        MODE_ADD,
        MODE_R,
        MODE_I,
        MODE_BRANCH
    } alu_mode_e;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE_S,
        ST_EXECUTE_R,
        ST_EXECUTE_I,
        ST_ALU_WB,
        ST_LUI,
        ST_JALR_ADR,
        ST_JAL,
        ST_BRANCH,
        ST_HALT
    } state_e;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// rtl/control_unit_alu_decoder.sv - funct3/funct7 to ALU_OP decode for R, I and branch modes
module control_unit_alu_decoder
    import control_unit_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (mode)
            MODE_R, MODE_I: begin
                case (funct3)
                    // funct7_5 only selects SUB for register operands; ADDI reuses that bit as immediate
                    3'b000:  alu_op = (mode == MODE_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            MODE_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV32I main control FSM driving ALU op, mux selects and write strobes
module control_unit
    import control_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       FUNCT7_5,
    input  logic       ZERO,
    output logic [3:0] ALU_OP,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] RESULT_SRC,
    output logic       ADR_SRC,
    output logic [2:0] IMM_SRC,
    output logic       IR_WRITE,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_WRITE,
    output logic       ILLEGAL
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] alu_mode;
    logic       ir_write, pc_write, reg_write, mem_write;
    logic       branch_ok, branch_take;

    control_unit_alu_decoder u_alu_decoder (
        .mode     (alu_mode),
        .funct3   (FUNCT3),
        .funct7_5 (FUNCT7_5),
        .alu_op   (ALU_OP)
    );

    // BLT/BLTU/BNE take on a nonzero compare, the rest on zero
    assign branch_ok   = (FUNCT3[2:1] != 2'b01);
    assign branch_take = ZERO ^ (FUNCT3[2] ^ FUNCT3[0]);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (OPCODE)
                    OP_LOAD, OP_STORE: state_d = ST_MEM_ADR;
                    OP_R:              state_d = ST_EXECUTE_R;
                    OP_I:              state_d = ST_EXECUTE_I;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    OP_JALR:           state_d = ST_JALR_ADR;
                    OP_LUI:            state_d = ST_LUI;
                    OP_AUIPC:          state_d = ST_ALU_WB;
                    default:           state_d = ST_HALT;
                endcase
            end
            ST_MEM_ADR:     state_d = (OPCODE == OP_STORE) ? ST_MEM_WRITE_S : ST_MEM_READ;
            ST_MEM_READ:    state_d = ST_MEM_WB;
            ST_MEM_WB:      state_d = ST_FETCH;
            ST_MEM_WRITE_S: state_d = ST_FETCH;
            ST_EXECUTE_R:   state_d = ST_ALU_WB;
            ST_EXECUTE_I:   state_d = ST_ALU_WB;
            ST_ALU_WB:      state_d = ST_FETCH;
            ST_LUI:         state_d = ST_ALU_WB;
            ST_JALR_ADR:    state_d = ST_JAL;
            ST_JAL:         state_d = ST_ALU_WB;
            ST_BRANCH:      state_d = branch_ok ? ST_FETCH : ST_HALT;
            default:        state_d = ST_HALT;
        endcase
        illegal_d = illegal_q | (state_d == ST_HALT);
    end

    always_comb begin
        ALU_SRC_A  = SRC_A_PC;
        ALU_SRC_B  = SRC_B_RD2;
        RESULT_SRC = RES_ALU_OUT;
        ADR_SRC    = 1'b0;
        alu_mode   = MODE_ADD;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ALU_SRC_B  = SRC_B_FOUR;
                RESULT_SRC = RES_ALU;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
            end
            ST_DECODE: begin
                ALU_SRC_A = SRC_A_OLD_PC;
                ALU_SRC_B = SRC_B_IMM;
            end
            ST_MEM_ADR, ST_JALR_ADR: begin
                ALU_SRC_A = SRC_A_RD1;
                ALU_SRC_B = SRC_B_IMM;
            end
            ST_MEM_READ: ADR_SRC = 1'b1;
            ST_MEM_WB: begin
                RESULT_SRC = RES_DATA;
                reg_write  = 1'b1;
            end
            ST_MEM_WRITE_S: begin
                ADR_SRC   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECUTE_R: begin
                ALU_SRC_A = SRC_A_RD1;
                alu_mode  = MODE_R;
            end
            ST_EXECUTE_I: begin
                ALU_SRC_A = SRC_A_RD1;
                ALU_SRC_B = SRC_B_IMM;
                alu_mode  = MODE_I;
            end
            ST_ALU_WB: reg_write = 1'b1;
            ST_LUI: begin
                ALU_SRC_A = SRC_A_ZERO;
                ALU_SRC_B = SRC_B_IMM;
            end
            ST_JAL: begin
                ALU_SRC_A = SRC_A_OLD_PC;
                ALU_SRC_B = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            ST_BRANCH: begin
                ALU_SRC_A = SRC_A_RD1;
                alu_mode  = MODE_BRANCH;
                pc_write  = branch_ok & branch_take;
            end
            default: ;
        endcase

        case (OPCODE)
            OP_STORE:         IMM_SRC = IMM_S;
            OP_BRANCH:        IMM_SRC = IMM_B;
            OP_JAL:           IMM_SRC = IMM_J;
            OP_LUI, OP_AUIPC: IMM_SRC = IMM_U;
            default:          IMM_SRC = IMM_I;
        endcase
    end

    // Strobes are masked while reset is held since the reset state is FETCH
    assign IR_WRITE  = RSTN & ir_write;
    assign PC_WRITE  = RSTN & pc_write;
    assign REG_WRITE = RSTN & reg_write;
    assign MEM_WRITE = RSTN & mem_write;
    assign ILLEGAL   = illegal_q;

endmodule
